// File: rtl/dp_accum_unit_pkg.sv
// rtl/dp_accum_unit_pkg.sv - shared types, defaults and latency helper for the dp accumulator
package dp_accum_unit_pkg;

  localparam int DW_ADD_DEF = 32;
  localparam int DW_ACC_DEF = 40;
  localparam int CNT_W_DEF  = 8;
  localparam int N_MUL_DEF  = 4;

  // Accumulator state: IDLE means the next retiring tile starts a fresh element.
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_e;

  // Tag travelling alongside an operand pair through the dp unit.
  typedef struct packed {
    logic v;
    logic last;
  } dp_tag_t;

  // The dp unit is a 3-stage front end plus a log2(n_mul)-deep adder tree.
  function automatic int dp_lat(input int n_mul);
    return 3 + $clog2(n_mul);
  endfunction

  localparam int DP_LAT_DEF = dp_lat(N_MUL_DEF);

endpackage

// File: rtl/dp_accum_unit_tag_pipe.sv
// rtl/dp_accum_unit_tag_pipe.sv - enable-gated tag delay line matching the dp unit latency
module dp_tag_pipe
  import dp_accum_unit_pkg::*;
#(
  parameter int DEPTH = DP_LAT_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    enable,
  input  dp_tag_t tag_in,
  output dp_tag_t tag_out,
  output logic    any_valid
);

  dp_tag_t stages [DEPTH];

  // Shift tags forward only on cycles where the dp unit itself advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else if (enable) begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  // Any valid tag anywhere in the line means work is still in flight.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stages[i].v;
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/dp_accum_unit.sv
// rtl/dp_accum_unit.sv - K-tile accumulator behind the dp unit; DP_ACC_SAT_EN selects saturating adds
module dp_accum_unit
  import dp_accum_unit_pkg::*;
#(
  parameter int DW_ADD = DW_ADD_DEF,
  parameter int DW_ACC = DW_ACC_DEF,
  parameter int DP_LAT = DP_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     issue_valid,
  input  logic                     issue_last,
  input  logic signed [DW_ADD-1:0] dp_out,
  output logic                     stall,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DW_ACC-1:0] out_data,
  output logic [CNT_W-1:0]         out_tiles,
  output logic                     busy
);

  acc_state_e               state, state_next;
  logic signed [DW_ACC-1:0] acc;
  logic signed [DW_ACC-1:0] acc_base;
  logic signed [DW_ACC-1:0] acc_sum;
  logic signed [DW_ACC-1:0] dp_ext;
  logic [CNT_W-1:0]         tile_cnt;
  logic [CNT_W-1:0]         cnt_next;
  logic                     overrun;
  dp_tag_t                  tag_in;
  dp_tag_t                  tag_ret;
  logic                     tags_busy;
  logic                     retire;
  logic                     retire_last;
  logic                     accept;

  assign tag_in = {issue_valid, issue_valid & issue_last};

  dp_tag_pipe #(
    .DEPTH (DP_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .tag_in    (tag_in),
    .tag_out   (tag_ret),
    .any_valid (tags_busy)
  );

  assign retire      = enable & tag_ret.v;
  assign retire_last = retire & tag_ret.last;
  assign accept      = out_valid & out_ready;
  assign stall       = out_valid & ~out_ready;
  assign busy        = tags_busy | (state == ACC) | out_valid;

  assign dp_ext   = DW_ACC'(dp_out);
  assign acc_base = (state == ACC) ? acc : '0;
  assign cnt_next = (state == ACC) ? tile_cnt + 1'b1 : CNT_W'(1);

`ifdef DP_ACC_SAT_EN
  logic signed [DW_ACC:0] sum_wide;
  logic                   sat_clamp;
  logic                   sat_hit;

  // Add one bit wider and clamp when the top two bits disagree.
  always_comb begin
    sum_wide  = {acc_base[DW_ACC-1], acc_base} + {dp_ext[DW_ACC-1], dp_ext};
    sat_clamp = sum_wide[DW_ACC] ^ sum_wide[DW_ACC-1];
    acc_sum   = sum_wide[DW_ACC-1:0];
    if (sat_clamp) begin
      acc_sum = sum_wide[DW_ACC] ? {1'b1, {(DW_ACC-1){1'b0}}}
                                 : {1'b0, {(DW_ACC-1){1'b1}}};
    end
  end

  // Sticky clamp flag, cleared by accepting a result; a new clamp in the same cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_hit <= 1'b0;
    end else begin
      if (accept) sat_hit <= 1'b0;
      if (retire && sat_clamp) sat_hit <= 1'b1;
    end
  end
`else
  // Plain two's complement wrap-around add.
  always_comb begin
    acc_sum = acc_base + dp_ext;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: every retire either continues the element or closes it.
  always_comb begin
    state_next = state;
    if (retire) state_next = tag_ret.last ? IDLE : ACC;
  end

  // Running sum and tile count, updated once per retiring tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      tile_cnt <= '0;
    end else if (retire) begin
      acc      <= acc_sum;
      tile_cnt <= cnt_next;
    end
  end

  // Output register: load on last retire unless the old result is still unaccepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tiles <= '0;
      overrun   <= 1'b0;
    end else if (retire_last) begin
      if (stall) begin
        overrun <= 1'b1;
      end else begin
        out_valid <= 1'b1;
        out_data  <= acc_sum;
        out_tiles <= cnt_next;
      end
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dp_accum_unit.sv
// tb/tb_dp_accum_unit.sv - table-driven scoreboard bench for dp_accum_unit
module tb_dp_accum_unit;

  localparam int DW_ADD = 32;
  localparam int DW_ACC = 40;
  localparam int DP_LAT = 5;
  localparam int CNT_W  = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     enable;
  logic                     issue_valid;
  logic                     issue_last;
  logic signed [DW_ADD-1:0] dp_out;
  logic                     stall;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DW_ACC-1:0] out_data;
  logic [CNT_W-1:0]         out_tiles;
  logic                     busy;

  always #5 clk = ~clk;

  dp_accum_unit #(
    .DW_ADD (DW_ADD),
    .DW_ACC (DW_ACC),
    .DP_LAT (DP_LAT),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .issue_valid (issue_valid),
    .issue_last  (issue_last),
    .dp_out      (dp_out),
    .stall       (stall),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tiles   (out_tiles),
    .busy        (busy)
  );

  typedef struct {
    int     n;
    int     v0;
    int     v1;
    int     v2;
    int     v3;
    longint exp_sum;
    int     exp_tiles;
  } vec_t;

  typedef struct {
    longint data;
    int     tiles;
  } exp_t;

  vec_t  tbl [11];
  exp_t  sb_q [$];
  logic signed [DW_ADD-1:0] pipe [DP_LAT];
  int    checks   = 0;
  int    failures = 0;
  int    lat_cnt  = 0;
  bit    lat_armed = 1'b0;
  logic  ov_prev  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int pick(input vec_t t, input int k);
    case (k)
      0:       return t.v0;
      1:       return t.v1;
      2:       return t.v2;
      default: return t.v3;
    endcase
  endfunction

  // One clock: drive, gate enable with stall, score any accepted output, then advance the dp model.
  task automatic step(input logic iv, input logic il, input int v, input logic en,
                      input logic rdy, output logic took);
    exp_t e;
    out_ready   = rdy;
    issue_valid = iv;
    issue_last  = il & iv;
    #1;
    took   = en & ~stall;
    enable = took;
    if (!took) begin
      issue_valid = 1'b0;
      issue_last  = 1'b0;
    end
    #1;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0d required=none", $signed(out_data));
      end else begin
        e = sb_q.pop_front();
        chk("out_data", $signed(out_data), e.data);
        chk("out_tiles", longint'(out_tiles), longint'(e.tiles));
      end
    end
    @(posedge clk);
    #1;
    if (took) begin
      for (int i = DP_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = v;
    end
    dp_out = pipe[DP_LAT-1];
    lat_cnt++;
    if (lat_armed && out_valid && !ov_prev) begin
      chk("latency", lat_cnt, DP_LAT + 1);
      lat_armed = 1'b0;
    end
    ov_prev = out_valid;
  endtask

  task automatic run_elem(input int idx, input bit toggle, input logic rdy, input bit check_lat);
    vec_t t;
    exp_t e;
    logic took;
    logic d;
    int   tries;
    bit   last;
    t = tbl[idx];
    for (int k = 0; k < t.n; k++) begin
      last  = (k == t.n - 1);
      took  = 1'b0;
      tries = 0;
      while (!took && tries < 50) begin
        if (last) begin
          lat_cnt   = 0;
          lat_armed = check_lat;
        end
        step(1'b1, last, pick(t, k), 1'b1, rdy, took);
        tries++;
      end
      if (!took) begin
        checks++;
        failures++;
        $display("FAIL issue_timeout actual=not_taken required=taken elem=%0d", idx);
      end else if (last) begin
        e.data  = t.exp_sum;
        e.tiles = t.exp_tiles;
        sb_q.push_back(e);
      end
      if (toggle) step(1'b0, 1'b0, 0, 1'b0, rdy, d);
    end
  endtask

  task automatic drain(input logic rdy);
    logic d;
    int   n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid || busy) && n < 60) begin
      step(1'b0, 1'b0, 0, 1'b1, rdy, d);
      n++;
    end
    chk("drain_done", longint'(sb_q.size() == 0 && !out_valid && !busy), 1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < DP_LAT; i++) pipe[i] = '0;
    dp_out    = '0;
    ov_prev   = 1'b0;
    lat_armed = 1'b0;
  endtask

  initial begin
    logic d;
    int   hi;
    int   rises;
    logic prev;

    tbl[0]  = '{4, 10, -3, 7, 100, 114, 4};
    tbl[1]  = '{1, -5, 0, 0, 0, -5, 1};
    tbl[2]  = '{3, 1, 2, 3, 0, 6, 3};
    tbl[3]  = '{2, 4, 4, 0, 0, 8, 2};
    tbl[4]  = '{2, 1, 1, 0, 0, 2, 2};
    tbl[5]  = '{2, 2, 2, 0, 0, 4, 2};
    tbl[6]  = '{2, 3, 3, 0, 0, 6, 2};
    tbl[7]  = '{1, 7, 0, 0, 0, 7, 1};
    tbl[8]  = '{1, 9, 0, 0, 0, 9, 1};
    tbl[9]  = '{2, 5, 6, 0, 0, 11, 2};
    tbl[10] = '{1, 9, 0, 0, 0, 9, 1};

    reset       = 1'b1;
    enable      = 1'b0;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    out_ready   = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_tiles", longint'(out_tiles), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_stall", longint'(stall), 0);
    @(negedge clk);
    reset = 1'b0;

    // Four-tile element with latency measurement.
    run_elem(0, 1'b0, 1'b1, 1'b1);
    drain(1'b1);
    chk("latency_seen", longint'(lat_armed), 0);

    // Single-tile negative element.
    run_elem(1, 1'b0, 1'b1, 1'b0);
    drain(1'b1);
    chk("state_idle", longint'(u_dut.state), 0);

    // Enable toggling between issues.
    run_elem(2, 1'b1, 1'b1, 1'b0);
    drain(1'b1);

    // Backpressure: hold 6 while the 4+4 element is stalled in flight.
    run_elem(2, 1'b0, 1'b0, 1'b0);
    run_elem(3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 0, 1'b1, 1'b0, d);
      if (out_valid && sb_q.size() > 0) chk("held_data", $signed(out_data), sb_q[0].data);
    end
    chk("held_valid", longint'(out_valid), 1);
    chk("held_stall", longint'(stall), 1);
    drain(1'b1);
    chk("overrun", longint'(u_dut.overrun), 0);

    // Back-to-back two-tile elements.
    run_elem(4, 1'b0, 1'b1, 1'b0);
    run_elem(5, 1'b0, 1'b1, 1'b0);
    run_elem(6, 1'b0, 1'b1, 1'b0);
    drain(1'b1);

    // Consecutive single-tile elements: accept and reload in the same cycle.
    run_elem(7, 1'b0, 1'b1, 1'b0);
    run_elem(8, 1'b0, 1'b1, 1'b0);
    hi    = 0;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 0, 1'b1, 1'b1, d);
      if (out_valid) hi++;
      if (out_valid && !prev) rises++;
      prev = out_valid;
    end
    chk("b2b_valid_cycles", hi, 2);
    chk("b2b_valid_rises", rises, 1);
    drain(1'b1);

    // Reset with a held result and three tags in flight.
    run_elem(10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1, 1'b1, 1'b0, d);
    step(1'b1, 1'b0, 2, 1'b1, 1'b0, d);
    step(1'b1, 1'b0, 3, 1'b1, 1'b0, d);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, d);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, d);
    chk("pre_reset_valid", longint'(out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_out_data", $signed(out_data), 0);
    chk("mid_rst_out_tiles", longint'(out_tiles), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    sb_q.delete();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    enable      = 1'b0;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_elem(9, 1'b0, 1'b1, 1'b0);
    drain(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dp_accum_unit.md
Name: dp_accum_unit

Overview:
- Downstream stage of the dot-product unit: consumes its DW_ADD-bit partial dot products and accumulates K-tiles into one output element.
- Tracks issued operand pairs through a tag delay line of DP_LAT enable-cycles, so each dp result is summed exactly once.
- Emits the finished sum on a valid/ready interface toward the output writeback buffer.

Parameters:
- DW_ADD, 32, width of the dp result input (signed).
- DW_ACC, 40, accumulator and output width (signed); must be ≥ DW_ADD.
- DP_LAT, 5, enable-cycles from issue_valid sampled to the matching dp_out being valid (5 for N_MUL=4).
- CNT_W, 8, width of the tile counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  pipeline advance; the same signal drives the dp unit's enable.
- issue_valid  in  1  an operand pair enters the dp unit this cycle.
- issue_last  in  1  the issued pair is the final K-tile of the element; ignored unless issue_valid.
- dp_out  in  DW_ADD  signed dp result.
- stall  out  1  combinational; high = out_valid && !out_ready; the top level gates enable with it.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_data  out  DW_ACC  accumulated sum.
- out_tiles  out  CNT_W  number of tiles summed into out_data.
- busy  out  1  any tag in flight or partial sum active.

Behaviour:
- Reset: all tags cleared, acc=0, tile_cnt=0, out_valid=0, out_data=0, out_tiles=0, state IDLE. Reset mid-operation discards in-flight tags and any partial sum.
- Tag delay line: DP_LAT stages of {v, last}. It shifts only when enable=1. Stage 0 loads {issue_valid, issue_valid & issue_last}. With enable=0, all state holds, including acc.
- Retire: on an enable cycle where the tag at stage DP_LAT-1 has v=1, dp_out is sign-extended to DW_ACC.
  - State IDLE: acc ← dp_out, tile_cnt ← 1.
  - State ACC: acc ← acc + dp_out, tile_cnt ← tile_cnt + 1.
  - Arithmetic wraps (two's complement) in the base build.
  - A tile_cnt wrap at 2^CNT_W wraps silently.
- Finish: if the retiring tag has last=1, the new sum and count load into out_data/out_tiles, out_valid is set, and state returns to IDLE. A single-tile element (issue_last on the first issue) is legal.
- States:
  - IDLE → ACC on a non-last retire.
  - ACC → ACC on a non-last retire.
  - ACC or IDLE → IDLE on a last retire.
- Output handshake: out_valid stays high with out_data stable until out_valid && out_ready; it then clears unless a new last retire occurs the same cycle, in which case the new result loads and out_valid stays 1.
- Backpressure: while stall=1 the top level holds enable=0. An enable=1 last retire while out_valid && !out_ready is a protocol error. The block then drops the new result, keeps the old one, and asserts the sticky overrun flag (internal, visible via hierarchy); state still returns to IDLE.
- Latency: out_valid rises the clock edge after the enable cycle in which the last tag retires, i.e. DP_LAT+1 enable-cycles after the issue of the last pair.
- busy = any tag v | (state==ACC) | out_valid.

Optional Feature:
- DP_ACC_SAT_EN defined: add and sign-extend saturate to [-2^(DW_ACC-1), 2^(DW_ACC-1)-1]; a sticky sat_hit bit is set on clamp and cleared when a result is accepted.
- Undefined: plain wrap-around, no sat_hit logic.

Decomposition:
- Shared package: DW_ACC/CNT_W defaults, state encoding (IDLE=0, ACC=1), the tag struct {v, last}, and the function dp_lat(n_mul) = 3 + log2(n_mul) for deriving DP_LAT.
- One sub-module: dp_tag_pipe (parameterised enable-gated shift register of tags, DP_LAT deep, async reset).

Test Plan:
- Four issues with dp_out 10, -3, 7, 100 (last on the 4th), enable always 1, out_ready=1 → out_valid pulses once, 6 cycles after the 4th issue, with out_data=114 and out_tiles=4.
- Single issue with last, dp_out=-5 → out_data=-5, out_tiles=1; state returns to IDLE.
- enable toggled 1,0,1,0… during a 3-tile element (1,2,3) → same result 6, with retire counted only on enable cycles; no double-adds.
- out_ready=0 holding result 6, top gates enable by stall, second element 4+4 issued → first 6 held stable until ready; then 8 emerges; no overrun.
- Back-to-back elements (last every 2 issues, values 1,1,2,2,3,3) with out_ready=1 → results 2,4,6 on consecutive retire boundaries; same-cycle accept+load keeps out_valid=1.
- Reset asserted with 3 tags in flight → outputs immediately 0, busy=0; next element computes cleanly. With DP_ACC_SAT_EN and DW_ACC=40: sum 2^39-1 plus 1 → out_data=2^39-1, sat_hit=1.
